wb_ooo_slave: RTL and testbench
===============================

# wb_ooo_slave

Parametrised Wishbone B4 pipelined slave with a tagged, out-of-order completion queue. It replaces the fixed 64-bit single-response slave endpoint in the out-of-order testbench environment. It accepts up to DEPTH outstanding requests and retires each one after a per-request latency taken from TGC_I. Every response carries the request tag on TGD_O, so a master can check reordered completions against a backing word memory.

## Interface
- DW, 64: data width; multiple of 8.
- AW, 16: word-address width of ADR_I.
- TW, 16: tag width of TGA_I, TGC_I and TGD_O.
- DEPTH, 4: maximum outstanding requests (2..16).
- MEM_WORDS, 256: memory size in words; addresses at or above it are out of range.
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-low.
- CYC_I  in  1  bus cycle; deassertion aborts all outstanding requests.
- STB_I  in  1  request strobe.
- WE_I  in  1  1 = write, 0 = read.
- ADR_I  in  AW  word address.
- DAT_I  in  DW  write data.
- SEL_I  in  DW/8  byte enables; writes only.
- TGA_I  in  TW  request tag, echoed on TGD_O.
- TGC_I  in  TW  bits [3:0] give the requested latency L (0..15); other bits ignored.
- STALL_O  out  1  queue full; request not accepted.
- ACK_O  out  1  normal termination.
- ERR_O  out  1  error termination (out-of-range address).
- RTY_O  out  1  retry termination (tag collision).
- DAT_O  out  DW  read data; 0 on write, ERR and RTY responses.
- TGD_O  out  TW  tag of the retiring request.
- OUTSTANDING  out  $clog2(DEPTH+1)  count of valid queue entries.

## Operation
- Accept: at a posedge with CYC_I & STB_I & !STALL_O.
- STALL_O: registered, equals (OUTSTANDING == DEPTH).
  - A retire and an accept may happen on the same edge.
  - When full, no accept happens even if a retire occurs on that edge.
- Slot allocation: an accepted request takes the lowest-index free slot. The slot stores tag, response kind, read data and a 4-bit countdown.
- Classification at accept, in priority order:
  1. ADR_I >= MEM_WORDS: ERR entry, countdown 0, no memory access.
  2. TGA_I equals the tag of any valid entry: RTY entry, countdown 0, no memory access.
  3. Otherwise: ACK entry, countdown L.
- ACK write: memory is updated at the accept edge; for each i with SEL_I[i]=1, DAT_I[8i+7:8i] is written.
- ACK read: the full word is captured at the accept edge and SEL_I is ignored. A read therefore sees every write accepted before it.
- Countdown: each edge, every valid entry with a nonzero countdown decrements by 1; the count saturates at 0.
- Retire: at each edge, among valid entries whose countdown was 0 before the edge, the lowest slot index retires.
  - Exactly one of ACK_O, ERR_O or RTY_O is asserted for one cycle, with TGD_O and DAT_O from that entry.
  - Losers of the arbitration stay eligible for the next edge.
  - At most one response per cycle.
- Abort: CYC_I=0 at an edge invalidates all entries.
  - No further responses are produced.
  - Writes already performed remain in memory.
- Reset (rst=0, asynchronous):
  - All entries invalid; OUTSTANDING=0.
  - ACK_O, ERR_O, RTY_O and STALL_O = 0; DAT_O and TGD_O = 0.
  - Memory is not reset.

## Timing
- Request accepted at edge E with latency L, uncontended: the response is asserted in the cycle after edge E+1+L.
  - The master samples it at edge E+2+L.
  - ERR and RTY always use L=0.
- ACK_O, ERR_O and RTY_O are single-cycle pulses; there is no back-to-back repeat of the same tag.
- OUTSTANDING updates at the edge: +1 on accept, −1 on retire, net 0 when both occur.
- STALL_O follows OUTSTANDING with the same edge.
- When an entry retires while CYC_I=0, abort takes precedence: no response is produced.
- Deasserting rst takes effect on the next edge; the first accept is possible at the first edge with rst=1.

## Test plan
- Reset check: drive rst=0 mid-traffic -> all termination outputs and STALL_O drop to 0 immediately, and OUTSTANDING=0.
- Write then read: write 0x1122334455667788 to addr 5 with SEL=0xFF, TGA=1, L=0 at edge E -> ACK with TGD=1 after E+1. Then read addr 5 with TGA=2, L=3 at E+1 -> ACK, TGD=2, DAT=0x1122334455667788 after E+5.
- Reordering and byte enables:
  - Read tag 0x10 with L=6, then read tag 0x11 with L=0 on the next edge -> 0x11 completes before 0x10.
  - Byte write with SEL=0x01, DAT=0xAB -> only byte 0 changes.
- Full queue: four requests with L=15 -> STALL_O=1 and OUTSTANDING=4; a fifth STB is held. After the first ACK, STALL_O=0 and the fifth is accepted.
- Error paths:
  - Read addr 300 (MEM_WORDS=256) -> ERR_O, DAT_O=0.
  - Reuse a live tag -> RTY_O and memory unchanged.
- Contention and abort:
  - Two entries eligible at the same edge -> the lower slot responds first and the other on the next cycle.
  - Drop CYC_I with 3 entries outstanding -> OUTSTANDING=0 and no further terminations.

Source files
------------

// File: rtl/wb_ooo_slave_if.sv
// Wishbone B4 pipelined bus bundle for the tagged out-of-order slave.
// Request handshake: a request transfers on any posedge where CYC_I & STB_I & !STALL_O;
// while STALL_O is high the master holds STB_I and all request fields stable.
interface wb_ooo_slave_if #(
    parameter int DW    = 64,
    parameter int AW    = 16,
    parameter int TW    = 16,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            CYC_I;
    logic            STB_I;
    logic            WE_I;
    logic [AW-1:0]   ADR_I;
    logic [DW-1:0]   DAT_I;
    logic [DW/8-1:0] SEL_I;
    logic [TW-1:0]   TGA_I;
    logic [TW-1:0]   TGC_I;
    logic            STALL_O;
    logic            ACK_O;
    logic            ERR_O;
    logic            RTY_O;
    logic [DW-1:0]   DAT_O;
    logic [TW-1:0]   TGD_O;
    logic [CW-1:0]   OUTSTANDING;

    modport master (
        output CYC_I, STB_I, WE_I, ADR_I, DAT_I, SEL_I, TGA_I, TGC_I,
        input  STALL_O, ACK_O, ERR_O, RTY_O, DAT_O, TGD_O, OUTSTANDING
    );

    modport slave (
        input  CYC_I, STB_I, WE_I, ADR_I, DAT_I, SEL_I, TGA_I, TGC_I,
        output STALL_O, ACK_O, ERR_O, RTY_O, DAT_O, TGD_O, OUTSTANDING
    );
endinterface

// File: rtl/wb_ooo_slave.sv
// Wishbone B4 pipelined slave: DEPTH tagged slots, each retiring after its own latency,
// lowest eligible slot first, backed by a word memory with byte-enabled writes.
module wb_ooo_slave #(
    parameter int DW        = 64,
    parameter int AW        = 16,
    parameter int TW        = 16,
    parameter int DEPTH     = 4,
    parameter int MEM_WORDS = 256
) (
    input  logic           clk,
    input  logic           rst,
    wb_ooo_slave_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(DEPTH);
    localparam int MW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    typedef enum logic [1:0] {
        K_ACK = 2'd0,
        K_ERR = 2'd1,
        K_RTY = 2'd2
    } kind_e;

    logic [DW-1:0]  mem_q [MEM_WORDS];

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [TW-1:0]    tag_q   [DEPTH];
    logic [TW-1:0]    tag_d   [DEPTH];
    kind_e            kind_q  [DEPTH];
    kind_e            kind_d  [DEPTH];
    logic [DW-1:0]    data_q  [DEPTH];
    logic [DW-1:0]    data_d  [DEPTH];
    logic [3:0]       cnt_q   [DEPTH];
    logic [3:0]       cnt_d   [DEPTH];

    logic [CW-1:0]    count_q, count_d;
    logic             stall_q, stall_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             rty_q, rty_d;
    logic [DW-1:0]    dat_q, dat_d;
    logic [TW-1:0]    tgd_q, tgd_d;

    logic             accept;
    logic             in_range;
    logic             collide;
    logic             free_ok;
    logic [SW-1:0]    free_idx;
    logic             ret_ok;
    logic [SW-1:0]    ret_idx;
    logic [MW-1:0]    adr_idx;
    logic             mem_we;

    assign accept   = bus.CYC_I & bus.STB_I & ~stall_q;
    assign in_range = 32'(bus.ADR_I) < MEM_WORDS;
    assign adr_idx  = bus.ADR_I[MW-1:0];
    assign mem_we   = accept & in_range & ~collide & bus.WE_I;

    // Downward scans so the lowest index wins both the free-slot and retire searches.
    always_comb begin
        free_ok  = 1'b0;
        free_idx = '0;
        ret_ok   = 1'b0;
        ret_idx  = '0;
        collide  = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_ok  = 1'b1;
                free_idx = SW'(i);
            end
            if (valid_q[i] && cnt_q[i] == 4'd0) begin
                ret_ok  = 1'b1;
                ret_idx = SW'(i);
            end
            if (valid_q[i] && tag_q[i] == bus.TGA_I) begin
                collide = 1'b1;
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        kind_d  = kind_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rty_d   = 1'b0;
        dat_d   = '0;
        tgd_d   = '0;

        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && cnt_q[i] != 4'd0) begin
                cnt_d[i] = cnt_q[i] - 4'd1;
            end
        end

        if (ret_ok) begin
            valid_d[ret_idx] = 1'b0;
            count_d          = count_d - CW'(1);
            ack_d            = (kind_q[ret_idx] == K_ACK);
            err_d            = (kind_q[ret_idx] == K_ERR);
            rty_d            = (kind_q[ret_idx] == K_RTY);
            dat_d            = data_q[ret_idx];
            tgd_d            = tag_q[ret_idx];
        end

        if (accept && free_ok) begin
            valid_d[free_idx] = 1'b1;
            tag_d[free_idx]   = bus.TGA_I;
            count_d           = count_d + CW'(1);
            if (!in_range) begin
                kind_d[free_idx] = K_ERR;
                data_d[free_idx] = '0;
                cnt_d[free_idx]  = 4'd0;
            end else if (collide) begin
                kind_d[free_idx] = K_RTY;
                data_d[free_idx] = '0;
                cnt_d[free_idx]  = 4'd0;
            end else begin
                kind_d[free_idx] = K_ACK;
                data_d[free_idx] = bus.WE_I ? '0 : mem_q[adr_idx];
                cnt_d[free_idx]  = bus.TGC_I[3:0];
            end
        end

        // Dropping CYC_I wins over everything, including a retire on the same edge.
        if (!bus.CYC_I) begin
            valid_d = '0;
            count_d = '0;
            ack_d   = 1'b0;
            err_d   = 1'b0;
            rty_d   = 1'b0;
            dat_d   = '0;
            tgd_d   = '0;
        end

        stall_d = (count_d == CW'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            count_q <= '0;
            stall_q <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rty_q   <= 1'b0;
            dat_q   <= '0;
            tgd_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i]  <= '0;
                kind_q[i] <= K_ACK;
                data_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            stall_q <= stall_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rty_q   <= rty_d;
            dat_q   <= dat_d;
            tgd_q   <= tgd_d;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i]  <= tag_d[i];
                kind_q[i] <= kind_d[i];
                data_q[i] <= data_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end

    // Memory contents survive reset and abort.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < DW / 8; b++) begin
                if (bus.SEL_I[b]) begin
                    mem_q[adr_idx][8*b +: 8] <= bus.DAT_I[8*b +: 8];
                end
            end
        end
    end

    assign bus.STALL_O     = stall_q;
    assign bus.ACK_O       = ack_q;
    assign bus.ERR_O       = err_q;
    assign bus.RTY_O       = rty_q;
    assign bus.DAT_O       = dat_q;
    assign bus.TGD_O       = tgd_q;
    assign bus.OUTSTANDING = count_q;
endmodule

// File: tb/tb_wb_ooo_slave.sv
// Directed bench for wb_ooo_slave: ordering, byte enables, backpressure, ERR/RTY, abort, reset.
module tb_wb_ooo_slave;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   n_term;

  wb_ooo_slave_if #(.DW(64), .AW(16), .TW(16), .DEPTH(4)) bus ();

  wb_ooo_slave #(.DW(64), .AW(16), .TW(16), .DEPTH(4), .MEM_WORDS(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic we, input logic [15:0] adr, input logic [63:0] dat,
                     input logic [7:0] sel, input logic [15:0] tga, input logic [3:0] lat);
    bus.STB_I = 1'b1;
    bus.WE_I  = we;
    bus.ADR_I = adr;
    bus.DAT_I = dat;
    bus.SEL_I = sel;
    bus.TGA_I = tga;
    bus.TGC_I = {12'h000, lat};
  endtask

  task automatic idle();
    bus.STB_I = 1'b0;
    bus.WE_I  = 1'b0;
    bus.ADR_I = '0;
    bus.DAT_I = '0;
    bus.SEL_I = '0;
    bus.TGA_I = '0;
    bus.TGC_I = '0;
  endtask

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  function automatic logic [3:0] terms();
    return {1'b0, bus.ACK_O, bus.ERR_O, bus.RTY_O};
  endfunction

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    bus.CYC_I = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("reset_terms", 64'(terms()), 64'h0);
    check("reset_stall", 64'(bus.STALL_O), 64'h0);
    check("reset_outstanding", 64'(bus.OUTSTANDING), 64'h0);
    check("reset_tgd_dat", 64'(bus.TGD_O) | bus.DAT_O, 64'h0);

    // write then read, first request on the first edge with rst high
    rst       = 1'b1;
    bus.CYC_I = 1'b1;
    req(1'b1, 16'd5, 64'h1122334455667788, 8'hFF, 16'h0001, 4'd0);
    step();
    check("wr_accept_outstanding", 64'(bus.OUTSTANDING), 64'd1);
    check("wr_no_early_ack", 64'(terms()), 64'h0);
    req(1'b0, 16'd5, 64'h0, 8'h00, 16'h0002, 4'd3);
    step();
    check("wr_ack", 64'(terms()), 64'h4);
    check("wr_ack_tgd", 64'(bus.TGD_O), 64'h1);
    check("wr_ack_dat_zero", bus.DAT_O, 64'h0);
    check("wr_rd_outstanding", 64'(bus.OUTSTANDING), 64'd1);
    idle();
    n_term = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (terms() != 4'h0) n_term++;
    end
    check("rd_latency_quiet", 64'(n_term), 64'd0);
    step();
    check("rd_ack", 64'(terms()), 64'h4);
    check("rd_tgd", 64'(bus.TGD_O), 64'h2);
    check("rd_dat", bus.DAT_O, 64'h1122334455667788);

    // byte write touches byte 0 only
    req(1'b1, 16'd5, 64'h00000000000000AB, 8'h01, 16'h0003, 4'd0);
    step();
    idle();
    step();
    check("bw_ack_tgd", 64'(bus.TGD_O), 64'h3);
    req(1'b0, 16'd5, 64'h0, 8'hFF, 16'h0004, 4'd0);
    step();
    idle();
    step();
    check("bw_readback", bus.DAT_O, 64'h11223344556677AB);

    // reorder: long-latency read overtaken by a zero-latency one
    req(1'b0, 16'd5, 64'h0, 8'h00, 16'h0010, 4'd6);
    step();
    req(1'b0, 16'd5, 64'h0, 8'h00, 16'h0011, 4'd0);
    step();
    idle();
    step();
    check("reorder_first_ack", 64'(terms()), 64'h4);
    check("reorder_first_tgd", 64'(bus.TGD_O), 64'h11);
    n_term = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (terms() != 4'h0) n_term++;
    end
    check("reorder_quiet", 64'(n_term), 64'd0);
    step();
    check("reorder_second_tgd", 64'(bus.TGD_O), 64'h10);
    check("reorder_second_dat", bus.DAT_O, 64'h11223344556677AB);

    // full queue, held fifth request, then same-edge contention
    for (int t = 0; t < 4; t++) begin
      req(1'b0, 16'd5, 64'h0, 8'h00, 16'h0020 + 16'(t), 4'd15);
      step();
    end
    check("full_outstanding", 64'(bus.OUTSTANDING), 64'd4);
    check("full_stall", 64'(bus.STALL_O), 64'd1);
    req(1'b0, 16'd5, 64'h0, 8'h00, 16'h0024, 4'd0);
    n_term = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (terms() != 4'h0 || bus.STALL_O !== 1'b1) n_term++;
    end
    check("full_held", 64'(n_term), 64'd0);
    check("full_held_outstanding", 64'(bus.OUTSTANDING), 64'd4);
    step();
    check("full_first_tgd", 64'(bus.TGD_O), 64'h20);
    check("full_first_ack", 64'(terms()), 64'h4);
    check("full_unstall", 64'(bus.STALL_O), 64'd0);
    check("full_first_outstanding", 64'(bus.OUTSTANDING), 64'd3);
    step();
    check("fifth_accepted_outstanding", 64'(bus.OUTSTANDING), 64'd3);
    check("second_tgd", 64'(bus.TGD_O), 64'h21);
    idle();
    step();
    check("contend_low_slot_tgd", 64'(bus.TGD_O), 64'h24);
    step();
    check("contend_loser_tgd", 64'(bus.TGD_O), 64'h22);
    step();
    check("contend_last_tgd", 64'(bus.TGD_O), 64'h23);
    check("drained_outstanding", 64'(bus.OUTSTANDING), 64'd0);

    // out-of-range address
    req(1'b0, 16'd300, 64'h0, 8'hFF, 16'h0030, 4'd5);
    step();
    idle();
    step();
    check("err_terms", 64'(terms()), 64'h2);
    check("err_tgd", 64'(bus.TGD_O), 64'h30);
    check("err_dat_zero", bus.DAT_O, 64'h0);

    // live-tag reuse gets RTY and does not write memory
    req(1'b0, 16'd5, 64'h0, 8'h00, 16'h0040, 4'd10);
    step();
    req(1'b1, 16'd5, 64'h0, 8'hFF, 16'h0040, 4'd0);
    step();
    req(1'b0, 16'd5, 64'h0, 8'h00, 16'h0041, 4'd0);
    step();
    check("rty_terms", 64'(terms()), 64'h1);
    check("rty_tgd", 64'(bus.TGD_O), 64'h40);
    check("rty_dat_zero", bus.DAT_O, 64'h0);
    req(1'b0, 16'd5, 64'h0, 8'h00, 16'h0042, 4'd15);
    step();
    check("rty_mem_tgd", 64'(bus.TGD_O), 64'h41);
    check("rty_mem_unchanged", bus.DAT_O, 64'h11223344556677AB);
    req(1'b0, 16'd5, 64'h0, 8'h00, 16'h0043, 4'd15);
    step();
    check("abort_pre_outstanding", 64'(bus.OUTSTANDING), 64'd3);

    // abort with three outstanding
    idle();
    bus.CYC_I = 1'b0;
    step();
    check("abort_outstanding", 64'(bus.OUTSTANDING), 64'd0);
    bus.CYC_I = 1'b1;
    n_term = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (terms() != 4'h0) n_term++;
    end
    check("abort_no_terms", 64'(n_term), 64'd0);

    // asynchronous reset with the queue full
    for (int t = 0; t < 4; t++) begin
      req(1'b0, 16'd5, 64'h0, 8'h00, 16'h0050 + 16'(t), 4'd15);
      step();
    end
    check("prereset_stall", 64'(bus.STALL_O), 64'd1);
    idle();
    rst = 1'b0;
    #1;
    check("async_reset_stall", 64'(bus.STALL_O), 64'd0);
    check("async_reset_outstanding", 64'(bus.OUTSTANDING), 64'd0);
    step();
    rst = 1'b1;
    req(1'b0, 16'd5, 64'h0, 8'h00, 16'h0060, 4'd0);
    step();
    check("post_reset_accept", 64'(bus.OUTSTANDING), 64'd1);
    req(1'b0, 16'd5, 64'h0, 8'h00, 16'h0061, 4'd8);
    step();
    check("prereset_ack", 64'(terms()), 64'h4);
    idle();
    rst = 1'b0;
    #1;
    check("async_reset_terms", 64'(terms()), 64'h0);
    check("async_reset_tgd_dat", 64'(bus.TGD_O) | bus.DAT_O, 64'h0);
    check("async_reset_outstanding2", 64'(bus.OUTSTANDING), 64'd0);
    step();
    rst = 1'b1;
    n_term = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (terms() != 4'h0) n_term++;
    end
    check("post_reset_quiet", 64'(n_term), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
